// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - in-order pipeline hazard scoreboard: forwarding selects, load-use stall, branch flush
module hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              de_valid,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic              de_use_rs1,
    input  logic              de_use_rs2,
    input  logic [REG_AW-1:0] de_rd,
    input  logic              de_reg_write,
    input  logic              de_mem_read,
    input  logic              branch_taken,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    // Scoreboard entry k holds the instruction k stages past decode (1 = EX).
    logic              valid_q   [1:PIPE_DEPTH];
    logic [REG_AW-1:0] rd_q      [1:PIPE_DEPTH];
    logic              rw_q      [1:PIPE_DEPTH];
    logic              load_q    [1:PIPE_DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic              stall_d;
    logic              bubble_d;
    logic              hit1_load;
    logic              hit2_load;
    int                hit1_k;
    int                hit2_k;

    // Youngest-match search per operand; scanning oldest to youngest lets the youngest overwrite.
    always_comb begin
        fwd_sel1  = '0;
        fwd_sel2  = '0;
        hit1_load = 1'b0;
        hit2_load = 1'b0;
        hit1_k    = 0;
        hit2_k    = 0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (de_valid && de_use_rs1 && (de_rs1 != '0) &&
                valid_q[k] && rw_q[k] && (rd_q[k] == de_rs1)) begin
                fwd_sel1  = SEL_W'(k);
                hit1_load = load_q[k];
                hit1_k    = k;
            end
            if (de_valid && de_use_rs2 && (de_rs2 != '0) &&
                valid_q[k] && rw_q[k] && (rd_q[k] == de_rs2)) begin
                fwd_sel2  = SEL_W'(k);
                hit2_load = load_q[k];
                hit2_k    = k;
            end
        end
    end

    // Load-use stall only when the load is still too young to forward; a taken branch overrides it.
    always_comb begin
        stall_d  = 1'b0;
        if ((hit1_load && (hit1_k < LOAD_READY)) || (hit2_load && (hit2_k < LOAD_READY))) begin
            stall_d = 1'b1;
        end
        if (branch_taken) begin
            stall_d = 1'b0;
        end
        bubble_d = stall_d | branch_taken | ~de_valid;
    end

    assign stall       = stall_d;
    assign flush       = branch_taken;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    // Shift the scoreboard one stage per enabled edge; entry 1 gets decode or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                rd_q[k]    <= '0;
                rw_q[k]    <= 1'b0;
                load_q[k]  <= 1'b0;
            end
        end else if (en) begin
            for (int k = PIPE_DEPTH; k >= 2; k--) begin
                valid_q[k] <= valid_q[k-1];
                rd_q[k]    <= rd_q[k-1];
                rw_q[k]    <= rw_q[k-1];
                load_q[k]  <= load_q[k-1];
            end
            if (bubble_d) begin
                valid_q[1] <= 1'b0;
                rd_q[1]    <= '0;
                rw_q[1]    <= 1'b0;
                load_q[1]  <= 1'b0;
            end else begin
                valid_q[1] <= 1'b1;
                rd_q[1]    <= de_rd;
                rw_q[1]    <= de_reg_write;
                load_q[1]  <= de_mem_read;
            end
        end
    end

    // Saturating stall/flush event counters, frozen while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (en) begin
            if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (branch_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed table-driven bench for hazard_unit
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst, en, de_valid, de_use_rs1, de_use_rs2, de_reg_write, de_mem_read, branch_taken;
    logic [4:0]  de_rs1, de_rs2, de_rd;
    logic [1:0]  fwd_sel1, fwd_sel2, s_fwd_sel1, s_fwd_sel2;
    logic        stall, flush, s_stall, s_flush;
    logic [15:0] stall_count, flush_count;
    logic [1:0]  s_stall_count, s_flush_count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .rst(rst), .en(en), .de_valid(de_valid),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
        .de_rd(de_rd), .de_reg_write(de_reg_write), .de_mem_read(de_mem_read),
        .branch_taken(branch_taken),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall(stall), .flush(flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .de_valid(de_valid),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
        .de_rd(de_rd), .de_reg_write(de_reg_write), .de_mem_read(de_mem_read),
        .branch_taken(branch_taken),
        .fwd_sel1(s_fwd_sel1), .fwd_sel2(s_fwd_sel2), .stall(s_stall), .flush(s_flush),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    typedef struct {
        logic        en, dv;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        rw, mr, br;
        logic [1:0]  e_sel1, e_sel2;
        logic        e_stall, e_flush;
        logic [15:0] e_sc, e_fc;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic en_v, dv, input logic [4:0] rs1, rs2, input logic u1, u2,
                                input logic [4:0] rd, input logic rw, mr, br,
                                input logic [1:0] s1, s2, input logic st, fl, input logic [15:0] sc, fc);
        vec_t v;
        v.en = en_v; v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.mr = mr; v.br = br;
        v.e_sel1 = s1; v.e_sel2 = s2; v.e_stall = st; v.e_flush = fl; v.e_sc = sc; v.e_fc = fc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic en_v, dv, input logic [4:0] rs1, rs2, input logic u1, u2,
                         input logic [4:0] rd, input logic rw, mr, br);
        en = en_v; de_valid = dv; de_rs1 = rs1; de_rs2 = rs2; de_use_rs1 = u1; de_use_rs2 = u2;
        de_rd = rd; de_reg_write = rw; de_mem_read = mr; branch_taken = br;
    endtask

    initial begin
        //           en dv rs1 rs2 u1 u2 rd rw mr br | s1 s2 st fl sc fc
        tbl[0]  = mk(1, 1,  5,  6, 1, 1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1,  1,  2, 1, 1,  5, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1,  5,  5, 1, 1,  6, 1, 0, 0,   1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1,  5,  0, 1, 0,  7, 1, 1, 0,   2, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1,  7,  0, 1, 1,  8, 1, 0, 0,   1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 1,  7,  0, 1, 1,  8, 1, 0, 0,   2, 0, 0, 0, 1, 0);
        tbl[6]  = mk(1, 1,  0,  0, 0, 0,  0, 1, 0, 0,   0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 1,  0,  0, 1, 1, 10, 1, 1, 0,   0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(1, 1,  8,  0, 1, 0,  3, 1, 1, 0,   3, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 1,  3, 10, 1, 1, 11, 1, 0, 1,   1, 2, 0, 1, 1, 0);
        tbl[10] = mk(1, 1, 11,  3, 1, 1,  9, 1, 0, 0,   0, 2, 0, 0, 1, 1);
        tbl[11] = mk(1, 1,  0,  0, 0, 0, 12, 1, 0, 0,   0, 0, 0, 0, 1, 1);
        tbl[12] = mk(1, 1,  0,  0, 0, 0,  9, 1, 0, 0,   0, 0, 0, 0, 1, 1);
        tbl[13] = mk(1, 1,  9, 12, 1, 1,  0, 0, 0, 0,   1, 2, 0, 0, 1, 1);
        tbl[14] = mk(1, 0,  9, 12, 1, 1,  0, 0, 0, 0,   0, 0, 0, 0, 1, 1);
        tbl[15] = mk(0, 1,  9,  0, 1, 0,  0, 0, 0, 1,   3, 0, 0, 1, 1, 1);
        tbl[16] = mk(1, 1,  9,  0, 1, 0,  0, 0, 0, 0,   3, 0, 0, 0, 1, 1);

        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].en, tbl[i].dv, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
                  tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].br);
            #2;
            check("fwd_sel1",    i, 32'(fwd_sel1),    32'(tbl[i].e_sel1));
            check("fwd_sel2",    i, 32'(fwd_sel2),    32'(tbl[i].e_sel2));
            check("stall",       i, 32'(stall),       32'(tbl[i].e_stall));
            check("flush",       i, 32'(flush),       32'(tbl[i].e_flush));
            check("stall_count", i, 32'(stall_count), 32'(tbl[i].e_sc));
            check("flush_count", i, 32'(flush_count), 32'(tbl[i].e_fc));
            @(posedge clk);
            #1;
        end

        // Repeated self-dependent loads (lw x7,0(x7)) stall every other cycle; small counter saturates at 3.
        rst = 1'b1;
        drive(1, 1, 7, 0, 1, 0, 7, 1, 1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            #2;
            check("sat_stall",     i, 32'(s_stall),       32'(i % 2));
            check("sat_count_s",   i, 32'(s_stall_count), 32'((i / 2) > 3 ? 3 : (i / 2)));
            check("sat_count_big", i, 32'(stall_count),   32'(i / 2));
            @(posedge clk);
            #1;
        end
        #2;
        check("pre_rst_stall", 11, 32'(stall), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("post_rst_stall",   12, 32'(stall),         32'd0);
        check("post_rst_sel1",    12, 32'(fwd_sel1),      32'd0);
        check("post_rst_sc_s",    12, 32'(s_stall_count), 32'd0);
        check("post_rst_sc_big",  12, 32'(stall_count),   32'd0);
        check("post_rst_fc_big",  12, 32'(flush_count),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
